mdu_hilo_ctrl: RTL

MDU_HILO_CTRL -- requirements
Module: mdu_hilo_ctrl

---
 rtl/mdu_hilo_ctrl.sv | 107 ++++++++++
 1 files changed

// File: rtl/mdu_hilo_ctrl.sv
// mdu_hilo_ctrl: iterative 32-cycle multiply/divide unit writing results to the HI/LO pair.
// Define MDU_CANCEL_EN to add the cancel port that flushes an in-flight operation.
module mdu_hilo_ctrl (
    input  logic        clk,
    input  logic        resetn,
    input  logic        op_valid,
    output logic        op_ready,
    input  logic [1:0]  op_code,
    input  logic [31:0] src_a,
    input  logic [31:0] src_b,
    output logic        busy,
    output logic [1:0]  hilo_wen,
    output logic [31:0] hi_wdata,
    output logic [31:0] lo_wdata,
`ifdef MDU_CANCEL_EN
    input  logic        cancel,
`endif
    output logic        done
);
    typedef enum logic [1:0] {IDLE, MUL, DIV, WB} state_t;
    state_t      state;
    logic [31:0] hi, lo, opnd, mag_a, mag_b, nh, nl, fh, fl;
    logic [4:0]  cnt;
    logic        neg_h, neg_l, sa, sb, kill;
    logic [32:0] add_s, rem_s, diff;
    logic [63:0] prod;
`ifdef MDU_CANCEL_EN
    assign kill = cancel;
`else
    assign kill = 1'b0;
`endif
    // iteration runs on magnitudes; signs are reapplied when entering WB
    assign sa    = ~op_code[0] & src_a[31];
    assign sb    = ~op_code[0] & src_b[31];
    assign mag_a = sa ? -src_a : src_a;
    assign mag_b = sb ? -src_b : src_b;
    assign add_s = {1'b0, hi} + {1'b0, lo[0] ? opnd : 32'd0};
    assign rem_s = {hi, lo[31]};
    assign diff  = rem_s - {1'b0, opnd};
    assign nh    = state == MUL ? add_s[32:1] : diff[32] ? rem_s[31:0] : diff[31:0];
    assign nl    = state == MUL ? {add_s[0], lo[31:1]} : {lo[30:0], ~diff[32]};
    assign prod  = neg_h ? -{nh, nl} : {nh, nl};
    assign fh    = state == MUL ? prod[63:32] : neg_h ? -nh : nh;
    assign fl    = state == MUL ? prod[31:0] : neg_l ? -nl : nl;
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state    <= IDLE;
            op_ready <= 1'b1;
            busy     <= 1'b0;
            hilo_wen <= 2'b00;
            done     <= 1'b0;
            hi_wdata <= '0;
            lo_wdata <= '0;
            hi       <= '0;
            lo       <= '0;
            opnd     <= '0;
            cnt      <= '0;
            neg_h    <= 1'b0;
            neg_l    <= 1'b0;
        end else begin
            case (state)
                IDLE: if (op_valid && !kill) begin
                    hi       <= '0;
                    lo       <= mag_a;
                    opnd     <= mag_b;
                    cnt      <= '0;
                    neg_h    <= op_code[1] ? sa : sa ^ sb;
                    neg_l    <= sa ^ sb;
                    busy     <= 1'b1;
                    op_ready <= 1'b0;
                    if (!op_code[1]) state <= MUL;
                    else if (src_b != 32'd0) state <= DIV;
                    else begin
                        state    <= WB;
                        hilo_wen <= 2'b11;
                        done     <= 1'b1;
                        hi_wdata <= src_a;
                        lo_wdata <= '1;
                    end
                end
                MUL, DIV: if (kill) begin
                    state    <= IDLE;
                    op_ready <= 1'b1;
                    busy     <= 1'b0;
                end else begin
                    hi  <= nh;
                    lo  <= nl;
                    cnt <= cnt + 5'd1;
                    if (cnt == 5'd31) begin
                        state    <= WB;
                        hilo_wen <= 2'b11;
                        done     <= 1'b1;
                        hi_wdata <= fh;
                        lo_wdata <= fl;
                    end
                end
                default: begin
                    state    <= IDLE;
                    op_ready <= 1'b1;
                    busy     <= 1'b0;
                    hilo_wen <= 2'b00;
                    done     <= 1'b0;
                end
            endcase
        end
    end
endmodule
